// File: rtl/avalon_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mem_pkg
// Brief    : Shared types and default widths for the Avalon-MM memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package avalon_mem_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 29;
    localparam int DEFAULT_DATA_WIDTH  = 64;
    localparam int DEFAULT_BURST_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BURST = 2'd1,
        READ_BURST  = 2'd2
    } state_t;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mem_responder_if
// Brief    : Avalon-MM word-addressed burst bus between a master and responder.
// Revision : 1.0 - initial release
// ============================================================================
interface avalon_mem_responder_if
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int BURST_WIDTH = DEFAULT_BURST_WIDTH
) ();

    logic [ADDR_WIDTH-1:0]             address;
    logic [BURST_WIDTH-1:0]            burstcount;
    logic                              read;
    logic                              write;
    logic [DATA_WIDTH-1:0]             writedata;
    logic [byte_lanes(DATA_WIDTH)-1:0] byteenable;
    logic                              waitrequest;
    logic [DATA_WIDTH-1:0]             readdata;
    logic                              readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface
`default_nettype wire

// File: rtl/avalon_mem_bram.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mem_bram
// Brief    : Single-port byte-enabled RAM, synchronous read, pipelined output.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_mem_bram
    import avalon_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              we,
    input  logic                              re,
    input  logic [DEPTH_LOG2-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] be,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              rvalid
);

    localparam int c_lanes = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   r_mem  [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_valid;

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 is the RAM read register; later stages only advance on valid so
    // the output word holds between beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= re;
            if (re) begin
                r_data[0] <= r_mem[addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign rdata  = r_data[READ_LATENCY-1];
    assign rvalid = r_valid[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mem_responder
// Brief    : Avalon-MM burst responder on on-chip RAM with programmable stalls.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_mem_responder
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int BURST_WIDTH    = DEFAULT_BURST_WIDTH,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 2,
    parameter int WAIT_CYCLES    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    avalon_mem_responder_if.slave bus
);

    localparam int c_stall_w = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_stall_w-1:0] c_wait = c_stall_w'(WAIT_CYCLES);

    state_t                    r_state, w_next;
    logic [c_stall_w-1:0]      r_stall, w_stall_next;
    logic [MEM_DEPTH_LOG2-1:0] r_base;
    logic [BURST_WIDTH-1:0]    r_count, r_beat, r_ret;
    logic [BURST_WIDTH-1:0]    w_count;
    logic                      w_req, w_wait, w_accept;
    logic                      w_ram_we, w_ram_re, w_rvalid;
    logic [MEM_DEPTH_LOG2-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0]     w_rdata;

    assign w_req   = bus.read | bus.write;
    assign w_count = (bus.burstcount == '0) ? BURST_WIDTH'(1) : bus.burstcount;

    always_comb begin
        w_next       = r_state;
        w_stall_next = '0;
        w_wait       = 1'b0;
        w_accept     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_re     = 1'b0;
        w_ram_addr   = bus.address[MEM_DEPTH_LOG2-1:0];
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (r_stall < c_wait) begin
                        w_wait       = 1'b1;
                        w_stall_next = r_stall + 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        if (bus.write) begin
                            w_ram_we = 1'b1;
                            if (w_count > BURST_WIDTH'(1)) w_next = WRITE_BURST;
                        end else begin
                            w_ram_re = 1'b1;
                            w_next   = READ_BURST;
                        end
                    end
                end
            end
            WRITE_BURST: begin
                if (bus.write) begin
                    w_ram_we   = 1'b1;
                    w_ram_addr = r_base + MEM_DEPTH_LOG2'(r_beat);
                    if (r_beat == r_count - 1'b1) w_next = IDLE;
                end
            end
            READ_BURST: begin
                w_wait = 1'b1;
                if (r_beat < r_count) begin
                    w_ram_re   = 1'b1;
                    w_ram_addr = r_base + MEM_DEPTH_LOG2'(r_beat);
                end
                if (w_rvalid && (r_ret == r_count - 1'b1)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // A write beat coinciding with reset is abandoned, not committed.
        if (reset) begin
            w_ram_we = 1'b0;
            w_ram_re = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_stall <= '0;
            r_base  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_next;
            r_stall <= w_stall_next;
            if (w_accept) begin
                r_base  <= bus.address[MEM_DEPTH_LOG2-1:0];
                r_count <= w_count;
                r_beat  <= BURST_WIDTH'(1);
                r_ret   <= '0;
            end else begin
                if (w_ram_we || w_ram_re) r_beat <= r_beat + 1'b1;
                if (r_state == READ_BURST && w_rvalid) r_ret <= r_ret + 1'b1;
            end
        end
    end

    avalon_mem_bram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_LOG2  (MEM_DEPTH_LOG2),
        .READ_LATENCY(READ_LATENCY)
    ) u_bram (
        .clock (clock),
        .reset (reset),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .addr  (w_ram_addr),
        .wdata (bus.writedata),
        .be    (bus.byteenable),
        .rdata (w_rdata),
        .rvalid(w_rvalid)
    );

    assign bus.waitrequest   = reset | w_wait;
    assign bus.readdata      = w_rdata;
    assign bus.readdatavalid = w_rvalid;

    // Address bits above the RAM depth alias onto the same words.
    generate
        if (ADDR_WIDTH > MEM_DEPTH_LOG2) begin : g_addr_alias
            logic w_unused_addr_bits;
            assign w_unused_addr_bits = ^bus.address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_mem_responder
// Brief    : Scoreboard bench for avalon_mem_responder at 0, 1 and 3 wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_responder;
    import avalon_mem_pkg::*;

    localparam int AW  = 29;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [AW-1:0]             address;
    logic [BW-1:0]             burstcount;
    logic                      read;
    logic                      write;
    logic [DW-1:0]             writedata;
    logic [byte_lanes(DW)-1:0] byteenable;

    // sel picks the active responder: 0 -> 0 waits, 1 -> 1 wait, 2 -> 3 waits
    logic [1:0]    sel;
    logic [2:0]    wr_v;
    logic [2:0]    rdv_v;
    logic [DW-1:0] rd_v [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int unexpected = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        avalon_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();
        assign bus.address    = address;
        assign bus.burstcount = burstcount;
        assign bus.read       = read;
        assign bus.write      = write;
        assign bus.writedata  = writedata;
        assign bus.byteenable = byteenable;
        assign wr_v[g]        = bus.waitrequest;
        assign rdv_v[g]       = bus.readdatavalid;
        assign rd_v[g]        = bus.readdata;

        avalon_mem_responder #(
            .ADDR_WIDTH    (AW),
            .DATA_WIDTH    (DW),
            .BURST_WIDTH   (BW),
            .MEM_DEPTH_LOG2(10),
            .READ_LATENCY  (LAT),
            .WAIT_CYCLES   ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) dut (
            .clock(clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every readdatavalid beat must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rdv_v[sel] === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                unexpected++;
                $display("FAIL unexpected_readdatavalid: got readdatavalid=1 data %h at cycle %0d, required no beat", rd_v[sel], cyc);
            end else begin
                e = sb.pop_front();
                chk("read_data", rd_v[sel], e.data);
                chk("read_cycle", DW'(cyc), DW'(e.cyc));
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Presents a command, counts stall cycles, returns after the accept edge.
    task automatic issue(input string name, input bit is_wr, input bit both,
                         input logic [AW-1:0] a, input logic [BW-1:0] bc,
                         input logic [DW-1:0] d, input logic [7:0] be,
                         input int exp_stalls, output int acc);
        int stalls = 0;
        @(negedge clk);
        address    = a;
        burstcount = bc;
        writedata  = d;
        byteenable = be;
        write      = is_wr | both;
        read       = ~is_wr | both;
        #1;
        while (wr_v[sel] !== 1'b0 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk({name, "_stalls"}, DW'(stalls), DW'(exp_stalls));
        acc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                      input int stalls, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                      input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        int acc;
        int n;
        exp_t e;
        logic [DW-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        n = (bc == 0) ? 1 : int'(bc);
        issue(name, 1'b0, 1'b0, a, bc, '0, '0, stalls, acc);
        for (int k = 0; k < n; k++) begin
            e.data = ev[k];
            e.cyc  = acc + k + LAT - 1;
            sb.push_back(e);
        end
        idle();
        drain();
    endtask

    task automatic wbeat(input logic [DW-1:0] d);
        @(negedge clk);
        write     = 1'b1;
        writedata = d;
        #1;
        chk("wburst_waitrequest", DW'(wr_v[sel]), 0);
        @(posedge clk);
    endtask

    task automatic gap();
        @(negedge clk);
        write = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_waitrequest", DW'(wr_v[sel]), 1);
        chk("reset_readdatavalid", DW'(rdv_v[sel]), 0);
        chk("reset_readdata", rd_v[sel], 0);
        reset = 1'b0;
        #1;
        chk("idle_waitrequest", DW'(wr_v[sel]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int u0;
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        burstcount = '0;
        writedata  = '0;
        byteenable = '0;
        sel        = 2'd1;
        repeat (3) @(negedge clk);
        do_reset();

        // One wait cycle: single write, read back, aliasing, partial write
        issue("wr_single", 1'b1, 1'b0, 29'h0700_0000, 8'd1, 64'hDEAD_BEEF_CAFE_BABE, 8'hFF, 1, a);
        idle();
        rd("rd_same", 29'h0700_0000, 8'd1, 1, 64'hDEAD_BEEF_CAFE_BABE, '0, '0, '0);
        rd("rd_alias", 29'h0, 8'd1, 1, 64'hDEAD_BEEF_CAFE_BABE, '0, '0, '0);
        issue("wr_ones", 1'b1, 1'b0, 29'h5, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, a);
        idle();
        issue("wr_partial", 1'b1, 1'b0, 29'h5, 8'd1, 64'h0, 8'h0F, 1, a);
        idle();
        rd("rd_partial", 29'h5, 8'd1, 1, 64'hFFFF_FFFF_0000_0000, '0, '0, '0);

        // Wrapping write burst with a two-cycle gap after beat 1
        issue("wr_burst", 1'b1, 1'b0, 29'h3FE, 8'd4, 64'd1, 8'hFF, 1, a);
        wbeat(64'd2);
        gap();
        gap();
        wbeat(64'd3);
        wbeat(64'd4);
        idle();
        rd("rd_burst", 29'h3FE, 8'd4, 1, 64'd1, 64'd2, 64'd3, 64'd4);
        rd("rd_bc0", 29'h3FF, 8'd0, 1, 64'd2, '0, '0, '0);
        rd("rd_after_bc0", 29'h000, 8'd1, 1, 64'd3, '0, '0, '0);

        // Three wait cycles, read and write together: write wins
        sel = 2'd2;
        do_reset();
        u0 = unexpected;
        issue("both", 1'b0, 1'b1, 29'h10, 8'd1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 3, a);
        idle();
        repeat (8) @(negedge clk);
        chk("both_no_readdatavalid", DW'(unexpected - u0), 0);
        rd("both_readback", 29'h10, 8'd1, 3, 64'h1234_5678_9ABC_DEF0, '0, '0, '0);

        // Zero wait cycles, reset one cycle into an 8-beat read
        sel = 2'd0;
        do_reset();
        issue("wr_zero", 1'b1, 1'b0, 29'h20, 8'd1, 64'h0BAD_F00D_0000_0020, 8'hFF, 0, a);
        idle();
        u0 = unexpected;
        issue("rd8", 1'b0, 1'b0, 29'h20, 8'd8, '0, '0, 0, a);
        @(negedge clk);
        reset = 1'b1;
        read  = 1'b0;
        repeat (2) @(negedge clk);
        chk("midburst_reset_waitrequest", DW'(wr_v[sel]), 1);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("midburst_no_readdatavalid", DW'(unexpected - u0), 0);
        chk("post_reset_idle_waitrequest", DW'(wr_v[sel]), 0);
        rd("rd_after_reset", 29'h20, 8'd1, 0, 64'h0BAD_F00D_0000_0020, '0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
